// File: rtl/pixel_uart_tx.sv
// pixel_uart_tx: drains 12-bit pixels from a non-show-ahead FIFO and streams
// them over an 8N1 UART line. Every frame starts with SYNC_BYTE, and each pixel
// is sent as two bytes: {4'h0,pix[11:8]} first, then pix[7:0].
// Ports:
//   CLK        system clock, posedge
//   RST        synchronous active-high reset
//   en         permission to start a new pixel (sampled in IDLE only)
//   fifo_q     FIFO read data, valid the cycle after rdreq
//   rdempty    FIFO empty flag (sampled in IDLE only)
//   rdreq      one-cycle FIFO read strobe per pixel
//   txd        UART serial output, idle high
//   busy       high while a sync byte or pixel is in flight
//   frame_done one-cycle pulse once the last pixel of a frame has left txd
module pixel_uart_tx #(
  parameter int unsigned BAUD_DIV     = 434,
  parameter int unsigned FRAME_PIXELS = 307200,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic [11:0] fifo_q,
  input  logic        rdempty,
  output logic        rdreq,
  output logic        txd,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned CNT_W  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int unsigned BIT_W  = 4;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(9);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_POP   = 3'd2,
    S_LATCH = 3'd3,
    S_HI    = 3'd4,
    S_LO    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit;
  logic [11:0]       r_pix;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic              r_txd;
  logic              r_rdreq;
  logic              r_busy;
  logic              r_fd_pend;
  logic              r_frame_done;

  logic              w_serial;
  logic              w_byte_done;
  logic [7:0]        w_byte;
  logic [9:0]        w_frame;
  logic              w_txd_nxt;
  logic              w_rdreq_nxt;
  logic              w_fd_nxt;

  // Serialiser is active in the three byte-carrying states.
  assign w_serial    = (r_state == S_SYNC) || (r_state == S_HI) || (r_state == S_LO);
  assign w_byte_done = w_serial && (r_baud == BAUD_LAST) && (r_bit == BIT_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (en && !rdempty) begin
          w_state_nxt = (r_pix_cnt == '0) ? S_SYNC : S_POP;
        end
      end
      S_SYNC:  if (w_byte_done) w_state_nxt = S_POP;
      S_POP:   w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_HI;
      S_HI:    if (w_byte_done) w_state_nxt = S_LO;
      S_LO:    if (w_byte_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; every value here is registered before reaching a port.
  always_comb begin
    w_byte      = SYNC_BYTE;
    w_frame     = '1;
    w_txd_nxt   = 1'b1;
    w_rdreq_nxt = 1'b0;
    w_fd_nxt    = 1'b0;
    case (r_state)
      S_HI:    w_byte = {4'h0, r_pix[11:8]};
      S_LO:    w_byte = r_pix[7:0];
      default: w_byte = SYNC_BYTE;
    endcase
    // stop bit, data LSB first, start bit
    w_frame = {1'b1, w_byte, 1'b0};
    if (w_serial) begin
      w_txd_nxt = w_frame[r_bit];
    end
    // rdreq is high for exactly the cycle spent in POP
    w_rdreq_nxt = (w_state_nxt == S_POP);
    w_fd_nxt    = (r_state == S_LO) && w_byte_done && (r_pix_cnt == PIX_LAST);
  end

  // Datapath: baud/bit counters, pixel latch, frame counter, output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_baud       <= '0;
      r_bit        <= '0;
      r_pix        <= '0;
      r_pix_cnt    <= '0;
      r_txd        <= 1'b1;
      r_rdreq      <= 1'b0;
      r_busy       <= 1'b0;
      r_fd_pend    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_txd   <= w_txd_nxt;
      r_rdreq <= w_rdreq_nxt;
      // busy follows the line: txd lags the state by one register
      r_busy  <= (r_state != S_IDLE);
      // frame_done lands on the first idle cycle after the final stop bit
      r_fd_pend    <= w_fd_nxt;
      r_frame_done <= r_fd_pend;

      if (w_serial) begin
        if (r_baud == BAUD_LAST) begin
          r_baud <= '0;
          r_bit  <= (r_bit == BIT_LAST) ? '0 : r_bit + BIT_W'(1);
        end else begin
          r_baud <= r_baud + BAUD_W'(1);
        end
      end else begin
        r_baud <= '0;
        r_bit  <= '0;
      end

      if (r_state == S_LATCH) begin
        r_pix <= fifo_q;
      end

      if ((r_state == S_LO) && w_byte_done) begin
        r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + CNT_W'(1);
      end
    end
  end

  assign txd        = r_txd;
  assign rdreq      = r_rdreq;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
